// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state type for the systolic feed sequencer
package systolic_pkg;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int STEP_W = 4;

  // Number of FEED cycles needed to push every skewed operand through an n x n array
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  localparam int FEED_LEN = feed_len(N);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/systolic_feed_sequencer_if.sv
// rtl/systolic_feed_sequencer_if.sv - job control, operand memory and PE array feed bundle
interface systolic_feed_sequencer_if #(
  parameter int N  = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW
);

  logic                         start;
  logic                         abort;
  logic [N-1:0][N*DW-1:0]       mem_a;
  logic [N-1:0][N*DW-1:0]       mem_b;
  logic                         pe_clr;
  logic                         pe_en;
  logic [N-1:0][DW-1:0]         a_west;
  logic [N-1:0][DW-1:0]         b_north;
  logic [systolic_pkg::STEP_W-1:0] step;
  logic                         busy;
  logic                         done;

  // Job requester / observer side
  modport master (
    output start, abort, mem_a, mem_b,
    input  pe_clr, pe_en, a_west, b_north, step, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, abort, mem_a, mem_b,
    output pe_clr, pe_en, a_west, b_north, step, busy, done
  );

endinterface

// File: rtl/systolic_feed_sequencer.sv
// rtl/systolic_feed_sequencer.sv - snapshots A/B and feeds them skewed into an N x N systolic array
module systolic_feed_sequencer #(
  parameter int N  = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW
) (
  input  logic                       clk,
  input  logic                       rst,
  systolic_feed_sequencer_if.slave   bus
);

  import systolic_pkg::*;

  // Last feed index: t runs 0 .. feed_len(N)-1
  localparam int LAST_T = feed_len(N) - 1;

  state_t                   state_q, state_d;
  logic [STEP_W-1:0]        t_q, t_d;
  logic [N-1:0][N*DW-1:0]   a_snap_q, a_snap_d;
  logic [N-1:0][N*DW-1:0]   b_snap_q, b_snap_d;
  logic                     pe_clr_q, pe_clr_d;
  logic                     pe_en_q, pe_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [N-1:0][DW-1:0]     a_west_c;
  logic [N-1:0][DW-1:0]     b_north_c;

  // Next-state, feed index and snapshot capture; abort overrides every transition
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_snap_d = a_snap_q;
    b_snap_d = b_snap_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_snap_d = bus.mem_a;
          b_snap_d = bus.mem_b;
          state_d  = ST_CLEAR;
        end
        t_d = '0;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        t_d     = '0;
      end
      ST_FEED: begin
        if (t_q == STEP_W'(LAST_T)) begin
          state_d = ST_FLUSH;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      t_d     = '0;
    end
  end

  // Output flags are decoded from the next state so they line up with the state register
  always_comb begin
    pe_clr_d = (state_d == ST_CLEAR);
    pe_en_d  = (state_d == ST_FEED) || (state_d == ST_FLUSH);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // Single state register for the FSM, feed index, snapshots and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      a_snap_q <= '0;
      b_snap_q <= '0;
      pe_clr_q <= 1'b0;
      pe_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_snap_q <= a_snap_d;
      b_snap_q <= b_snap_d;
      pe_clr_q <= pe_clr_d;
      pe_en_q  <= pe_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Diagonal skew: row i sees A[i][j] and column j sees B[k][j] on the step where the index sum equals t
  always_comb begin
    a_west_c  = '0;
    b_north_c = '0;
    if (state_q == ST_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (int'(t_q) == i + j) begin
            a_west_c[i]  = a_snap_q[i][j*DW +: DW];
            b_north_c[j] = b_snap_q[i][j*DW +: DW];
          end
        end
      end
    end
  end

  assign bus.pe_clr  = pe_clr_q;
  assign bus.pe_en   = pe_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.a_west  = a_west_c;
  assign bus.b_north = b_north_c;
  assign bus.step    = (state_q == ST_FEED) ? t_q : '0;

endmodule

// File: doc/systolic_feed_sequencer.md
SYSTOLIC_FEED_SEQUENCER -- requirements
Module: systolic_feed_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: matrix dimension, i.e. PE rows and columns.
REQ-002 SHALL have parameter DW, default 8: operand element width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels the running job.
REQ-007 SHALL have port mem_a  input  N x (N*DW)  A rows; mem_a[i] byte j = A[i][j].
REQ-008 SHALL have port mem_b  input  N x (N*DW)  B rows; mem_b[k] byte j = B[k][j].
REQ-009 SHALL have port pe_clr  output  1  clears all PE accumulators.
REQ-010 SHALL have port pe_en  output  1  advances the array one step.
REQ-011 SHALL have port a_west  output  N x DW  skewed row operands, west edge.
REQ-012 SHALL have port b_north  output  N x DW  skewed column operands, north edge.
REQ-013 SHALL have port step  output  4  current feed index t.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, FEED, FLUSH, DONE.
REQ-017 SHALL, in IDLE with start=1, snapshot mem_a and mem_b into internal registers and go to CLEAR on the next edge.
REQ-018 SHALL assert pe_clr=1 for exactly the one CLEAR cycle, then enter FEED with t=0.
REQ-019 SHALL, in FEED, hold pe_en=1 and increment t each cycle over t=0..3N-3 (0..9 for N=4), then go to FLUSH.
REQ-020 SHALL drive a_west[i] = A[i][t-i] when 0<=t-i<N, else 0.
REQ-021 SHALL drive b_north[j] = B[t-j][j] when 0<=t-j<N, else 0.
REQ-022 SHALL drive a_west, b_north and step to 0 outside FEED.
REQ-023 SHALL hold pe_en=1 for the single FLUSH cycle with zero operands, then go to DONE.
REQ-024 SHALL assert done=1 for exactly the DONE cycle, then return to IDLE.
REQ-025 SHALL, for start at edge E, produce pe_clr in E+1, FEED in E+2..E+11, FLUSH in E+12, and done in E+13 (N=4).
REQ-026 SHALL ignore start while busy=1; start held high through DONE SHALL begin a new job only after IDLE is re-entered.
REQ-027 SHALL be unaffected by mem_a/mem_b changes after the snapshot edge.
REQ-028 SHALL, on abort=1 in any state other than IDLE, go to IDLE on the next edge with pe_en=0 and no done pulse; abort has priority over every other transition.
REQ-029 SHALL perform no arithmetic on operands; accumulator width is owned by the array.

Reset
REQ-030 SHALL, on rst=1, enter IDLE with t=0 and the snapshot registers cleared.
REQ-031 SHALL drive pe_clr, pe_en, busy, done, a_west, b_north and step to 0 during reset and in IDLE.
REQ-032 SHALL, when rst is asserted mid-job, abandon the job without a done pulse; rst has priority over abort and start.

Structure
REQ-033 SHALL take the state enum, N, DW and the feed-length constant 3N-2 from a shared package, systolic_pkg.
REQ-034 SHALL be a single module with no sub-modules; skew selection is combinational from t and the snapshot registers.

Verification
REQ-035 SHALL check A = identity, B[k][j] = 4k+j+1, start pulse: pe_clr at E+1, done at E+13, and the array C equals B.
REQ-036 SHALL check A = B = all 0x01: at t=3, a_west = {1,1,1,1} and b_north = {1,1,1,1}; at t=0, a_west = {1,0,0,0}.
REQ-037 SHALL check overwriting mem_a with 0xFF at E+5: C is unchanged from the snapshot result.
REQ-038 SHALL check abort at E+6: IDLE at E+7, pe_en=0 and no done pulse; a new start then completes normally.
REQ-039 SHALL check start held high continuously: exactly one job per 14 cycles, and start during FEED is ignored.
REQ-040 SHALL check rst asserted at t=4: all outputs 0 on the next edge and busy=0.
